// File: rtl/riscv_pkg.sv
// Shared core-wide constants and the fetch-queue entry layout.
// Used by the fetch unit and its prefetch queue.
package riscv_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned INSTR_W = 32;
    localparam int unsigned FETCH_W = XLEN + INSTR_W;

    localparam int unsigned FETCH_PC_LSB    = INSTR_W;
    localparam int unsigned FETCH_INSTR_LSB = 0;

    localparam logic [XLEN-1:0] PC_STEP          = 32'd4;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Packed so that pc lands in [63:32] and instr in [31:0].
    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return pc & ~(XLEN'(3));
    endfunction

endpackage

// File: rtl/sync_fifo_flush.sv
// Synchronous FIFO with a single-cycle flush that overrides push and pop.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo_flush #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push && !flush && !rst) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: drives imem, buffers {pc, instr} pairs and hands them to decode.
// A redirect flushes the prefetch queue and restarts fetch at the aligned target.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned     QDEPTH   = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    output logic [XLEN-1:0]             iaddr,
    input  logic [INSTR_W-1:0]          idata,
    input  logic                        fetch_en,
    input  logic                        redirect_valid,
    input  logic [XLEN-1:0]             redirect_pc,
    output logic                        inst_valid,
    input  logic                        inst_ready,
    output logic [INSTR_W-1:0]          inst_data,
    output logic [XLEN-1:0]             inst_pc,
    output logic [$clog2(QDEPTH+1)-1:0] q_count
);

    localparam int unsigned CW = $clog2(QDEPTH + 1);

    logic [XLEN-1:0] fetch_pc;
    logic            push;
    logic            pop;
    logic            not_empty;
    fetch_entry_t    wentry;
    fetch_entry_t    head;
    logic [FETCH_W-1:0] head_raw;

    assign not_empty  = (q_count != '0);
    assign inst_valid = not_empty && !redirect_valid;
    assign pop        = inst_valid && inst_ready;
    // A full queue still accepts a fetch when the head leaves in the same cycle.
    assign push       = fetch_en && !redirect_valid && ((q_count < CW'(QDEPTH)) || pop);

    assign wentry = '{pc: fetch_pc, instr: idata};
    assign head   = fetch_entry_t'(head_raw);

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
        end else if (redirect_valid) begin
            fetch_pc <= align_pc(redirect_pc);
        end else if (push) begin
            fetch_pc <= fetch_pc + PC_STEP;
        end
    end

    sync_fifo_flush #(
        .WIDTH(FETCH_W),
        .DEPTH(QDEPTH)
    ) u_queue (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect_valid),
        .push  (push),
        .pop   (pop),
        .wdata (wentry),
        .rdata (head_raw),
        .count (q_count)
    );

    assign iaddr     = fetch_pc;
    assign inst_data = not_empty ? head.instr : '0;
    assign inst_pc   = not_empty ? head.pc : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a scoreboard of expected {pc, instr} deliveries
// plus direct checks of occupancy, fetch address and handshake timing.
module tb_fetch_unit;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_en = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        inst_ready = 1'b0;

    logic [31:0] iaddr, idata, inst_data, inst_pc;
    logic        inst_valid;
    logic [2:0]  q_count;

    logic [31:0] iaddr2, idata2, inst_data2, inst_pc2;
    logic        inst_valid2;
    logic [2:0]  q_count2;

    int   checks = 0;
    int   errors = 0;
    exp_t expq[$];
    exp_t expq2[$];

    always #5 clk = ~clk;

    function automatic logic [31:0] imem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h0000_0013;
            32'h0000_0004: return 32'h0010_0093;
            32'h0000_0008: return 32'h0020_0113;
            32'h0000_000C: return 32'h0030_0193;
            default:       return a ^ 32'h5A5A_0013;
        endcase
    endfunction

    assign idata  = imem_word(iaddr);
    assign idata2 = imem_word(iaddr2);

    fetch_unit #(
        .RESET_PC(32'h0000_0000),
        .QDEPTH  (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .iaddr          (iaddr),
        .idata          (idata),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .q_count        (q_count)
    );

    fetch_unit #(
        .RESET_PC(32'hFFFF_FFF8),
        .QDEPTH  (4)
    ) dut_wrap (
        .clk            (clk),
        .rst            (rst),
        .iaddr          (iaddr2),
        .idata          (idata2),
        .fetch_en       (1'b1),
        .redirect_valid (1'b0),
        .redirect_pc    (32'h0),
        .inst_valid     (inst_valid2),
        .inst_ready     (1'b1),
        .inst_data      (inst_data2),
        .inst_pc        (inst_pc2),
        .q_count        (q_count2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] pc);
        exp_t e;
        e.pc   = pc;
        e.data = imem_word(pc);
        return e;
    endfunction

    // Compare any transfer happening in the current (settled) cycle.
    task automatic monitor();
        exp_t e;
        if (!rst && inst_valid === 1'b1 && inst_ready === 1'b1) begin
            if (expq.size() == 0) begin
                chk("unexpected_pop_pc", inst_pc, 32'hDEAD_BEEF);
            end else begin
                e = expq.pop_front();
                chk("pop_pc", inst_pc, e.pc);
                chk("pop_data", inst_data, e.data);
            end
        end
        if (!rst && inst_valid2 === 1'b1 && expq2.size() != 0) begin
            e = expq2.pop_front();
            chk("wrap_pc", inst_pc2, e.pc);
            chk("wrap_data", inst_data2, e.data);
        end
    endtask

    task automatic step();
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic fe, input logic rv,
                         input logic [31:0] rpc, input logic rdy);
        rst            = r;
        fetch_en       = fe;
        redirect_valid = rv;
        redirect_pc    = rpc;
        inst_ready     = rdy;
        #1;
    endtask

    initial begin
        // Reset then stream
        drive(1, 1, 0, 32'h0, 1);
        @(posedge clk); #1;
        step();
        chk("rst_iaddr", iaddr, 32'h0);
        chk("rst_valid", {31'b0, inst_valid}, 32'h0);
        chk("rst_data", inst_data, 32'h0);
        chk("rst_pc", inst_pc, 32'h0);
        chk("rst_count", {29'b0, q_count}, 32'h0);
        chk("wrap_rst_iaddr", iaddr2, 32'hFFFF_FFF8);
        for (int i = 0; i < 4; i++) expq.push_back(mk(32'(i * 4)));
        expq2.push_back(mk(32'hFFFF_FFF8));
        expq2.push_back(mk(32'hFFFF_FFFC));
        expq2.push_back(mk(32'h0000_0000));
        drive(0, 1, 0, 32'h0, 1);
        chk("first_cycle_valid", {31'b0, inst_valid}, 32'h0);
        step();
        for (int i = 0; i < 4; i++) begin
            chk("stream_valid", {31'b0, inst_valid}, 32'h1);
            step();
        end
        chk("stream_drained", 32'(expq.size()), 32'h0);
        chk("wrap_drained", 32'(expq2.size()), 32'h0);

        // Backpressure
        drive(1, 1, 0, 32'h0, 0);
        step();
        drive(0, 1, 0, 32'h0, 0);
        for (int i = 0; i < 10; i++) step();
        chk("bp_count", {29'b0, q_count}, 32'h4);
        chk("bp_iaddr", iaddr, 32'h10);
        chk("bp_valid", {31'b0, inst_valid}, 32'h1);
        for (int i = 0; i < 5; i++) expq.push_back(mk(32'(i * 4)));
        drive(0, 1, 0, 32'h0, 1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_release_valid", {31'b0, inst_valid}, 32'h1);
            step();
        end
        chk("bp_drained", 32'(expq.size()), 32'h0);

        // Redirect with queue full
        drive(0, 1, 0, 32'h0, 0);
        step();
        chk("pre_redirect_full", {29'b0, q_count}, 32'h4);
        drive(0, 1, 1, 32'h0000_0203, 1);
        chk("redir_cycle_valid", {31'b0, inst_valid}, 32'h0);
        step();
        drive(0, 1, 0, 32'h0, 1);
        chk("redir_next_valid", {31'b0, inst_valid}, 32'h0);
        chk("redir_count", {29'b0, q_count}, 32'h0);
        chk("redir_iaddr", iaddr, 32'h200);
        expq.push_back(mk(32'h200));
        expq.push_back(mk(32'h204));
        step();
        chk("redir_target_valid", {31'b0, inst_valid}, 32'h1);
        step();
        step();
        chk("redir_drained", 32'(expq.size()), 32'h0);

        // Redirect while fetch disabled
        drive(0, 0, 1, 32'h0000_0100, 1);
        step();
        drive(0, 0, 0, 32'h0, 1);
        chk("fe0_count", {29'b0, q_count}, 32'h0);
        chk("fe0_iaddr", iaddr, 32'h100);
        for (int i = 0; i < 3; i++) step();
        chk("fe0_hold_count", {29'b0, q_count}, 32'h0);
        chk("fe0_hold_iaddr", iaddr, 32'h100);
        expq.push_back(mk(32'h100));
        expq.push_back(mk(32'h104));
        drive(0, 1, 0, 32'h0, 1);
        chk("fe_rise_valid", {31'b0, inst_valid}, 32'h0);
        step();
        chk("fe_rise_next_valid", {31'b0, inst_valid}, 32'h1);
        step();
        step();
        chk("fe_drained", 32'(expq.size()), 32'h0);

        // Mid-stream reset with a pending redirect
        drive(0, 1, 1, 32'h0000_0300, 0);
        step();
        drive(0, 1, 0, 32'h0, 0);
        for (int i = 0; i < 3; i++) step();
        chk("mid_pre_count", {29'b0, q_count}, 32'h3);
        drive(1, 1, 1, 32'h0000_0500, 0);
        step();
        drive(0, 0, 0, 32'h0, 0);
        chk("mid_rst_count", {29'b0, q_count}, 32'h0);
        chk("mid_rst_valid", {31'b0, inst_valid}, 32'h0);
        chk("mid_rst_iaddr", iaddr, 32'h0);
        step();
        chk("mid_rst_hold_iaddr", iaddr, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
